// File: rtl/dcache_fifo_pkg.sv
// Shared types and constants for the dcache AXI request/response FIFOs.
// Used by the single-channel FIFO and its pointer/count core.
package dcache_fifo_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_ADDR_W    = 2;
    localparam int DEF_AFULL_LVL = 3;

    // Sticky error pair reported by every FIFO flavour.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // The count needs one bit more than the pointers to tell full from empty.
    function automatic int count_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_count.sv
// Read/write pointers and occupancy count for a power-of-two FIFO.
// Callers pass already-qualified enables; clear wins over both.
module fifo_ptr_count
    import dcache_fifo_pkg::*;
#(
    parameter  int ADDR_W  = DEF_ADDR_W,
    localparam int COUNT_W = count_w(ADDR_W)
) (
    input  logic               clk_i,
    input  logic               clear_i,
    input  logic               wr_en_i,
    input  logic               rd_en_i,
    output logic [ADDR_W-1:0]  wr_ptr_o,
    output logic [ADDR_W-1:0]  rd_ptr_o,
    output logic [COUNT_W-1:0] count_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(2 ** ADDR_W);
    localparam logic [ADDR_W-1:0]  PTR_ONE = ADDR_W'(1);
    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    logic [ADDR_W-1:0]  wr_ptr_q;
    logic [ADDR_W-1:0]  rd_ptr_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        unique case ({wr_en_i, rd_en_i})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointers are exactly ADDR_W bits, so DEPTH-1 + 1 wraps to 0 by itself.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_en_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;
    assign full_o   = (count_q == DEPTH_C);
    assign empty_o  = (count_q == '0);

endmodule

// File: rtl/axi_fifo_ctrl_flush.sv
// Show-ahead single-clock FIFO for the dcache AXI paths, with a local flush,
// occupancy/almost-full outputs and sticky overflow/underflow flags.
module axi_fifo_ctrl_flush
    import dcache_fifo_pkg::*;
#(
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int ADDR_W    = DEF_ADDR_W,
    parameter  int AFULL_LVL = DEF_AFULL_LVL,
    localparam int COUNT_W   = count_w(ADDR_W)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [WIDTH-1:0]   data_in_i,
    output logic               accept_o,
    input  logic               pop_i,
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_out_o,
    output logic [COUNT_W-1:0] level_o,
    output logic               almost_full_o,
    output logic               overflow_o,
    output logic               underflow_o
);

    localparam int                 DEPTH    = 2 ** ADDR_W;
    localparam logic [COUNT_W-1:0] AFULL_C  = COUNT_W'(AFULL_LVL);

    // Handshake: a word moves in on an edge where push_i && accept_o, and the
    // head is consumed on an edge where pop_i && valid_o. accept_o and valid_o
    // depend only on registered state, never on push_i/pop_i.
    logic               clear;
    logic               full;
    logic               empty;
    logic               wr_en;
    logic               rd_en;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [COUNT_W-1:0] count;
    logic [WIDTH-1:0]   mem [DEPTH];
    fifo_err_t          err_q;

    assign clear = !rst_ni || flush_i;
    assign wr_en = push_i && !full && !clear;
    assign rd_en = pop_i && !empty && !clear;

    fifo_ptr_count #(
        .ADDR_W (ADDR_W)
    ) u_ptr_count (
        .clk_i    (clk_i),
        .clear_i  (clear),
        .wr_en_i  (wr_en),
        .rd_en_i  (rd_en),
        .wr_ptr_o (wr_ptr),
        .rd_ptr_o (rd_ptr),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty)
    );

    // Storage is deliberately not reset; valid_o masks stale contents.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_in_i;
        end
    end

    // Only the global reset clears the sticky flags; a flush cycle records nothing.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= '0;
        end else if (!flush_i) begin
            if (push_i && full) begin
                err_q.overflow <= 1'b1;
            end
            if (pop_i && empty) begin
                err_q.underflow <= 1'b1;
            end
        end
    end

    assign accept_o      = !full;
    assign valid_o       = !empty;
    assign data_out_o    = mem[rd_ptr];
    assign level_o       = count;
    assign almost_full_o = (count >= AFULL_C);
    assign overflow_o    = err_q.overflow;
    assign underflow_o   = err_q.underflow;

endmodule
